tbird_seq_lights: RTL and testbench

- Parametrised tail-light sequencer, the successor to the fixed 3-lamp T-bird FSM.
- Drives N lamps per side with a thermometer-fill turn sequence and flashing hazards.
- A clock-divided step rate sets the animation speed; a brake input lights every non-signalling side.
- Sits between debounced driver-switch inputs and the lamp drivers.

---
 rtl/tbird_seq_lights.sv | 129 ++++++++++++
 tb/tb_tbird_seq_lights.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/tbird_seq_lights.sv
// Parametrised tail-light sequencer: N lamps per side, thermometer turn fill,
// flashing hazards, brake on every non-signalling side, stepped every DIV cycles.
module tbird_seq_lights #(
  parameter int N   = 3,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         left,
  input  logic         right,
  input  logic         haz,
  input  logic         brake,
  output logic [N-1:0] l_lights,
  output logic [N-1:0] r_lights,
  output logic         busy
);

  localparam int PW = $clog2(N + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2,
    ST_HAZ   = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] pos_reg, pos_next;
  logic [DW-1:0] div_reg, div_next;
  logic          tick;
  logic          haz_req;
  logic [N-1:0]  therm;

  assign tick    = (div_reg == DW'(DIV - 1));
  assign haz_req = haz | (left & right);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_reg <= ST_IDLE;
      pos_reg   <= '0;
      div_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pos_reg   <= pos_next;
      div_reg   <= div_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pos_next   = pos_reg;
    div_next   = '0;
    case (state_reg)
      ST_IDLE: begin
        if (haz_req) begin
          state_next = ST_HAZ;
          pos_next   = PW'(N);
        end else if (left) begin
          state_next = ST_LEFT;
          pos_next   = PW'(1);
        end else if (right) begin
          state_next = ST_RIGHT;
          pos_next   = PW'(1);
        end else begin
          pos_next   = '0;
        end
      end
      ST_LEFT, ST_RIGHT: begin
        div_next = tick ? '0 : div_reg + DW'(1);
        if (tick) begin
          if (haz) begin
            state_next = ST_HAZ;
            pos_next   = PW'(N);
          end else if (pos_reg == PW'(N)) begin
            pos_next = '0;
          end else if (pos_reg != '0) begin
            pos_next = pos_reg + PW'(1);
          end else if ((state_reg == ST_LEFT)  ? (left & ~right)
                                               : (right & ~left)) begin
            // Request still held at the dark step: restart without visiting IDLE.
            pos_next = PW'(1);
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_HAZ: begin
        div_next = tick ? '0 : div_reg + DW'(1);
        if (tick) begin
          if (pos_reg == PW'(N)) begin
            pos_next = '0;
          end else if (haz_req) begin
            pos_next = PW'(N);
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        pos_next   = '0;
        div_next   = '0;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_therm
      assign therm[gi] = (pos_reg > PW'(gi));
    end
  endgenerate

  always_comb begin
    l_lights = {N{brake}};
    r_lights = {N{brake}};
    busy     = (state_reg != ST_IDLE);
    case (state_reg)
      ST_LEFT:  l_lights = therm;
      ST_RIGHT: r_lights = therm;
      ST_HAZ: begin
        l_lights = therm;
        r_lights = therm;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tbird_seq_lights.sv
// Directed bench for tbird_seq_lights: N=3/DIV=4 main instance plus an
// N=5/DIV=1 instance for the one-cycle-per-step fill.
module tb_tbird_seq_lights;

  logic       clk = 1'b0;
  logic       rst_b, left, right, haz, brake;
  logic [2:0] l_lights, r_lights;
  logic       busy;
  logic       left_b;
  logic [4:0] l_lights_b, r_lights_b;
  logic       busy_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tbird_seq_lights #(.N(3), .DIV(4)) dut (
    .clk(clk), .rst_b(rst_b), .left(left), .right(right), .haz(haz),
    .brake(brake), .l_lights(l_lights), .r_lights(r_lights), .busy(busy)
  );

  tbird_seq_lights #(.N(5), .DIV(1)) dut_fast (
    .clk(clk), .rst_b(rst_b), .left(left_b), .right(1'b0), .haz(1'b0),
    .brake(1'b0), .l_lights(l_lights_b), .r_lights(r_lights_b), .busy(busy_b)
  );

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance n rising edges, then settle 1ns past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_lamps(input string tag, input logic [2:0] l_exp,
                             input logic [2:0] r_exp, input logic busy_exp);
    check_value({tag, ".l"}, 32'(l_lights), 32'(l_exp));
    check_value({tag, ".r"}, 32'(r_lights), 32'(r_exp));
    check_value({tag, ".busy"}, 32'(busy), 32'(busy_exp));
  endtask

  initial begin
    rst_b = 1'b0; left = 1'b0; right = 1'b0; haz = 1'b0; brake = 1'b0;
    left_b = 1'b0;
    step(2);
    check_lamps("reset", 3'b000, 3'b000, 1'b0);
    brake = 1'b1;
    #1 check_lamps("reset_brake", 3'b111, 3'b111, 1'b0);
    brake = 1'b0;

    // Left held from reset release, then dropped.
    rst_b = 1'b1; left = 1'b1;
    step(1); check_lamps("left_p1", 3'b001, 3'b000, 1'b1);
    step(3); check_lamps("left_p1_hold", 3'b001, 3'b000, 1'b1);
    step(1); check_lamps("left_p2", 3'b011, 3'b000, 1'b1);
    step(4); check_lamps("left_p3", 3'b111, 3'b000, 1'b1);
    step(4); check_lamps("left_dark", 3'b000, 3'b000, 1'b1);
    step(4); check_lamps("left_rerun", 3'b001, 3'b000, 1'b1);
    left = 1'b0;
    step(4); check_lamps("left_run_p2", 3'b011, 3'b000, 1'b1);
    step(4); check_lamps("left_run_p3", 3'b111, 3'b000, 1'b1);
    step(4); check_lamps("left_run_dark", 3'b000, 3'b000, 1'b1);
    step(4); check_lamps("left_idle", 3'b000, 3'b000, 1'b0);

    // Right pulsed for one cycle; busy for exactly 16 cycles.
    right = 1'b1;
    step(1); check_lamps("right_p1", 3'b000, 3'b001, 1'b1);
    right = 1'b0;
    step(4); check_lamps("right_p2", 3'b000, 3'b011, 1'b1);
    step(4); check_lamps("right_p3", 3'b000, 3'b111, 1'b1);
    step(4); check_lamps("right_dark", 3'b000, 3'b000, 1'b1);
    step(3); check_lamps("right_busy15", 3'b000, 3'b000, 1'b1);
    step(1); check_lamps("right_idle16", 3'b000, 3'b000, 1'b0);

    // Hazard preempts LEFT at pos=2.
    left = 1'b1;
    step(1); check_lamps("hz_left_p1", 3'b001, 3'b000, 1'b1);
    left = 1'b0;
    step(4); check_lamps("hz_left_p2", 3'b011, 3'b000, 1'b1);
    haz = 1'b1;
    step(3); check_lamps("hz_wait_tick", 3'b011, 3'b000, 1'b1);
    step(1); check_lamps("hz_on1", 3'b111, 3'b111, 1'b1);
    step(4); check_lamps("hz_off1", 3'b000, 3'b000, 1'b1);
    step(4); check_lamps("hz_on2", 3'b111, 3'b111, 1'b1);
    haz = 1'b0;
    step(4); check_lamps("hz_off2", 3'b000, 3'b000, 1'b1);
    step(4); check_lamps("hz_idle", 3'b000, 3'b000, 1'b0);

    // Left and right together behave as hazard.
    left = 1'b1; right = 1'b1;
    step(1); check_lamps("lr_on", 3'b111, 3'b111, 1'b1);
    left = 1'b0; right = 1'b0;
    step(4); check_lamps("lr_off", 3'b000, 3'b000, 1'b1);
    step(4); check_lamps("lr_idle", 3'b000, 3'b000, 1'b0);

    // Brake during LEFT, in IDLE and in HAZ.
    brake = 1'b1; left = 1'b1;
    step(1); check_lamps("brk_left_p1", 3'b001, 3'b111, 1'b1);
    left = 1'b0;
    step(4); check_lamps("brk_left_p2", 3'b011, 3'b111, 1'b1);
    step(4); check_lamps("brk_left_p3", 3'b111, 3'b111, 1'b1);
    step(4); check_lamps("brk_left_dark", 3'b000, 3'b111, 1'b1);
    step(4); check_lamps("brk_idle", 3'b111, 3'b111, 1'b0);
    haz = 1'b1;
    step(1); check_lamps("brk_haz_on", 3'b111, 3'b111, 1'b1);
    haz = 1'b0;
    step(4); check_lamps("brk_haz_off", 3'b000, 3'b000, 1'b1);
    step(4); check_lamps("brk_haz_idle", 3'b111, 3'b111, 1'b0);
    brake = 1'b0;

    // Reset aborts a sequence mid-way.
    left = 1'b1;
    step(1); check_lamps("rst_left_p1", 3'b001, 3'b000, 1'b1);
    left = 1'b0;
    step(4); check_lamps("rst_left_p2", 3'b011, 3'b000, 1'b1);
    rst_b = 1'b0;
    step(1); check_lamps("rst_abort", 3'b000, 3'b000, 1'b0);
    rst_b = 1'b1;
    step(1); check_lamps("rst_after", 3'b000, 3'b000, 1'b0);

    // N=5, DIV=1: one step per cycle.
    left_b = 1'b1;
    step(1);
    left_b = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      logic [4:0] exp_fill;
      exp_fill = 5'((32'd1 << k) - 1);
      check_value($sformatf("fast_fill%0d", k), 32'(l_lights_b), 32'(exp_fill));
      check_value($sformatf("fast_busy%0d", k), 32'(busy_b), 32'd1);
      step(1);
    end
    check_value("fast_dark", 32'(l_lights_b), 32'd0);
    check_value("fast_dark_busy", 32'(busy_b), 32'd1);
    check_value("fast_r", 32'(r_lights_b), 32'd0);
    step(1);
    check_value("fast_idle_busy", 32'(busy_b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
